gbinstr_feeder: RTL and testbench

GBINSTR_FEEDER -- requirements
Module: gbinstr_feeder

---
 rtl/gbinstr_feeder_if.sv | 23 ++
 rtl/gbinstr_feeder.sv | 137 +++++++++++++
 tb/tb_gbinstr_feeder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gbinstr_feeder_if.sv
// gbinstr_feeder_if: host-write, issue and status signals of the instruction feeder.
//   master : drives wr_instr/wr_en/hold, observes instruction/valid and status
//   slave  : the feeder itself
interface gbinstr_feeder_if #(parameter int DEPTH = 8);
    localparam int LW = $clog2(DEPTH) + 1;
    logic [7:0]    wr_instr;
    logic          wr_en;
    logic          hold;
    logic [7:0]    instruction;
    logic          valid;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic [15:0]   issue_count;
    modport master (
        output wr_instr, wr_en, hold,
        input  instruction, valid, full, level, overflow, issue_count
    );
    modport slave (
        input  wr_instr, wr_en, hold,
        output instruction, valid, full, level, overflow, issue_count
    );
endinterface

// File: rtl/gbinstr_feeder.sv
// gbinstr_feeder: byte FIFO that paces instruction bytes to gbprocessor, keeping 0xCB prefixes glued to their operand.
//   clock      : single rising-edge clock
//   reset      : asynchronous active-low reset
//   bus.slave  : wr_instr/wr_en/hold in; instruction/valid/full/level/overflow/issue_count out
module gbinstr_feeder #(
    parameter int DEPTH = 8,
    parameter int GAP   = 4
) (
    input  logic            clock,
    input  logic            reset,
    gbinstr_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_CB_WAIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [3:0]    gap_q, gap_d;
    logic [7:0]    instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          opnd_q, opnd_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   icnt_q, icnt_d;
    logic          empty, full, push, pop, prefix;

    assign empty  = count_q == '0;
    assign full   = count_q == LW'(DEPTH);
    assign push   = bus.wr_en & ~full;
    // the byte just issued opens a CB pair only if it was not itself an operand
    assign prefix = instr_q == 8'hCB && !opnd_q;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        opnd_d  = opnd_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !bus.hold) begin
                    pop     = 1'b1;
                    opnd_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (prefix) begin
                    if (!empty) begin
                        pop    = 1'b1;
                        opnd_d = 1'b1;
                    end else begin
                        state_d = S_CB_WAIT;
                    end
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = 4'(GAP);
                end else if (!empty && !bus.hold) begin
                    pop    = 1'b1;
                    opnd_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                gap_d = gap_q - 4'd1;
                // last gap cycle already acts as IDLE so the gap is exactly GAP cycles wide
                if (gap_q == 4'd1) begin
                    if (!empty && !bus.hold) begin
                        pop     = 1'b1;
                        opnd_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CB_WAIT: begin
                if (!empty) begin
                    pop     = 1'b1;
                    opnd_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + LW'(push) - LW'(pop);
        instr_d  = pop ? mem[rd_ptr_q] : instr_q;
        valid_d  = pop;
        icnt_d   = icnt_q + 16'(pop);
        ovf_d    = ovf_q | (bus.wr_en & full);
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= bus.wr_instr;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            opnd_q   <= 1'b0;
            ovf_q    <= 1'b0;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            opnd_q   <= opnd_d;
            ovf_q    <= ovf_d;
            icnt_q   <= icnt_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.valid       = valid_q;
    assign bus.full        = full;
    assign bus.level       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.issue_count = icnt_q;
endmodule

// File: tb/tb_gbinstr_feeder.sv
// tb_gbinstr_feeder: scoreboard bench for gbinstr_feeder with GAP=4 and GAP=0 instances.
module tb_gbinstr_feeder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    gbinstr_feeder_if #(.DEPTH(8)) a ();
    gbinstr_feeder_if #(.DEPTH(8)) b ();

    gbinstr_feeder #(.DEPTH(8), .GAP(4)) u_a (.clock(clock), .reset(reset), .bus(a.slave));
    gbinstr_feeder #(.DEPTH(8), .GAP(0)) u_b (.clock(clock), .reset(reset), .bus(b.slave));

    typedef struct {
        logic [7:0] b;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_a = 0;
    int   cnt_a = 0;
    int   nb_b = 0;
    int   last_b = 0;
    int   vc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin : mon_a
        exp_t e;
        if (reset && a.valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(a.valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("instr", 32'(a.instruction), 32'(e.b));
                if (e.gap >= 0) check("gap", cyc - last_a - 1, e.gap);
            end
            last_a = cyc;
            cnt_a++;
            check("issue_count", 32'(a.issue_count), 32'(cnt_a[15:0]));
        end
    end

    always @(negedge clock) begin : mon_b
        if (reset && b.valid) begin
            check("b_instr", 32'(b.instruction), 32'(nb_b[7:0]));
            if (nb_b > 0) check("b_b2b", cyc - last_b, 1);
            last_b = cyc;
            nb_b++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // gap: -1 don't care, -2 byte never issues (dropped or discarded)
    task automatic wr(input logic [7:0] v, input int gap);
        exp_t e;
        a.wr_en    = 1'b1;
        a.wr_instr = v;
        if (gap != -2) begin
            e.b   = v;
            e.gap = gap;
            exp_q.push_back(e);
        end
        step();
        a.wr_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!a.valid && n < 60) begin
            step();
            n++;
        end
        check(tag, 32'(a.valid), 32'd1);
    endtask

    task automatic count_valid(input int n, output int v);
        v = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (a.valid) v++;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
        repeat (6) step();
    endtask

    initial begin
        a.wr_en = 1'b0; a.wr_instr = '0; a.hold = 1'b0;
        b.wr_en = 1'b0; b.wr_instr = '0; b.hold = 1'b0;
        repeat (3) step();
        check("rst_instr", 32'(a.instruction), 32'd0);
        check("rst_valid", 32'(a.valid), 32'd0);
        check("rst_full", 32'(a.full), 32'd0);
        check("rst_level", 32'(a.level), 32'd0);
        check("rst_ovf", 32'(a.overflow), 32'd0);
        check("rst_icnt", 32'(a.issue_count), 32'd0);
        reset = 1'b1;
        step();
        step();
        check("release_valid", 32'(a.valid), 32'd0);

        // single byte followed by GAP idle cycles
        wr(8'h8C, -1);
        wait_valid("t33_valid");
        count_valid(4, vc);
        check("t33_idle", vc, 32'd0);
        check("t33_cnt", 32'(a.issue_count), 32'd1);
        step();
        step();

        // prefix waits for a late operand with no gap in between
        wr(8'hCB, -1);
        wait_valid("t34_prefix");
        count_valid(10, vc);
        check("t34_cbwait", vc, 32'd0);
        wr(8'h37, -1);
        step();
        check("t34_op_valid", 32'(a.valid), 32'd1);
        check("t34_op_instr", 32'(a.instruction), 32'h37);
        count_valid(4, vc);
        check("t34_gap", vc, 32'd0);
        step();

        // CB operand is not a new prefix: 0x8C still waits a full gap
        wr(8'hCB, -1);
        wr(8'hCB, 0);
        wr(8'h8C, 4);
        drain("t23_drain");

        // fill past full under hold, then release
        a.hold = 1'b1;
        for (int i = 0; i < 9; i++) wr(8'(8'h10 + i), i == 0 ? -1 : (i < 8 ? 4 : -2));
        check("t35_full", 32'(a.full), 32'd1);
        check("t35_level", 32'(a.level), 32'd8);
        check("t35_ovf", 32'(a.overflow), 32'd1);
        a.hold = 1'b0;
        drain("t35_drain");
        check("t35_empty_level", 32'(a.level), 32'd0);
        check("t35_empty_full", 32'(a.full), 32'd0);
        check("t35_ovf_sticky", 32'(a.overflow), 32'd1);

        // simultaneous push and pop keeps level
        a.hold = 1'b1;
        wr(8'h20, -1);
        wr(8'h21, 4);
        check("t16_level2", 32'(a.level), 32'd2);
        a.hold = 1'b0;
        wr(8'h22, 4);
        check("t16_level_same", 32'(a.level), 32'd2);
        drain("t16_drain");

        // hold during a gap does not stretch it
        wr(8'hA0, -1);
        wr(8'hA1, 4);
        wait_valid("t29_first");
        a.hold = 1'b1;
        step();
        step();
        a.hold = 1'b0;
        drain("t29_drain");

        // GAP=0 instance streams 256 bytes back to back
        b.wr_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b.wr_instr = 8'(i);
            step();
        end
        b.wr_en = 1'b0;
        for (int n = 0; n < 20 && nb_b < 256; n++) step();
        check("t36_pulses", nb_b, 32'd256);
        check("t36_icnt", 32'(b.issue_count), 32'd256);
        check("t36_level", 32'(b.level), 32'd0);

        // asynchronous reset in GAP with bytes queued
        wr(8'hB0, -1);
        wr(8'hB1, -2);
        wr(8'hB2, -2);
        wr(8'hB3, -2);
        check("t37_level", 32'(a.level), 32'd3);
        #1 reset = 1'b0;
        #1;
        check("t37_valid", 32'(a.valid), 32'd0);
        check("t37_instr", 32'(a.instruction), 32'd0);
        check("t37_level0", 32'(a.level), 32'd0);
        check("t37_full", 32'(a.full), 32'd0);
        check("t37_ovf", 32'(a.overflow), 32'd0);
        check("t37_icnt", 32'(a.issue_count), 32'd0);
        cnt_a = 0;
        step();
        step();
        reset = 1'b1;
        count_valid(12, vc);
        check("t37_no_valid", vc, 32'd0);
        wr(8'h55, -1);
        wait_valid("t37_fresh");
        drain("t37_drain");
        check("t37_cnt1", 32'(a.issue_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
